// File: rtl/comparator_seq.sv
// rtl/comparator_seq.sv - multi-cycle MSB-first chunked magnitude comparator with valid/ready handshake
module comparator_seq #(
   parameter int WIDTH      = 16,
   parameter int CHUNK      = 2,
   parameter int EARLY_EXIT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             signed_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             a_gt_b,
   output logic             a_eq_b,
   output logic             a_lt_b
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] SCAN = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]       state;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [IDXW-1:0]  idx;

   // First-difference record, only meaningful in full-scan mode
   logic             found;
   logic             rec_gt;
   logic             rec_lt;

   logic [CHUNK-1:0] chunk_a;
   logic [CHUNK-1:0] chunk_b;
   logic             chunk_gt;
   logic             chunk_lt;
   logic             chunk_ne;
   logic             res_gt;
   logic             res_lt;
   logic             res_eq;

   // Flipping the sign bit maps two's-complement order onto unsigned order
   logic [WIDTH-1:0] sign_flip;
   assign sign_flip = {signed_mode, {(WIDTH-1){1'b0}}};

   assign in_ready = (state == IDLE);

   // Current chunk compare and the full-scan result that favours the earliest difference
   always_comb begin
      chunk_a  = a_reg[int'(idx)*CHUNK +: CHUNK];
      chunk_b  = b_reg[int'(idx)*CHUNK +: CHUNK];
      chunk_gt = (chunk_a > chunk_b);
      chunk_lt = (chunk_a < chunk_b);
      chunk_ne = (chunk_a != chunk_b);
      res_gt   = found ? rec_gt : chunk_gt;
      res_lt   = found ? rec_lt : chunk_lt;
      res_eq   = ~(found | chunk_ne);
   end

   // Control FSM, operand capture, scan index and result flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         a_reg     <= '0;
         b_reg     <= '0;
         idx       <= '0;
         found     <= 1'b0;
         rec_gt    <= 1'b0;
         rec_lt    <= 1'b0;
         out_valid <= 1'b0;
         a_gt_b    <= 1'b0;
         a_eq_b    <= 1'b0;
         a_lt_b    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_reg  <= a ^ sign_flip;
                  b_reg  <= b ^ sign_flip;
                  idx    <= IDXW'(NCHUNK - 1);
                  found  <= 1'b0;
                  rec_gt <= 1'b0;
                  rec_lt <= 1'b0;
                  state  <= SCAN;
               end
            end
            SCAN: begin
               if (EARLY_EXIT != 0) begin
                  if (chunk_ne || (idx == '0)) begin
                     a_gt_b    <= chunk_gt;
                     a_lt_b    <= chunk_lt;
                     a_eq_b    <= ~chunk_ne;
                     out_valid <= 1'b1;
                     state     <= DONE;
                  end else begin
                     idx <= idx - IDXW'(1);
                  end
               end else begin
                  if (!found && chunk_ne) begin
                     found  <= 1'b1;
                     rec_gt <= chunk_gt;
                     rec_lt <= chunk_lt;
                  end
                  if (idx == '0) begin
                     a_gt_b    <= res_gt;
                     a_lt_b    <= res_lt;
                     a_eq_b    <= res_eq;
                     out_valid <= 1'b1;
                     state     <= DONE;
                  end else begin
                     idx <= idx - IDXW'(1);
                  end
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_comparator_seq.sv
// tb/tb_comparator_seq.sv - directed vector bench for comparator_seq in early-exit and full-scan builds
module tb_comparator_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        out_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic        signed_mode;

   logic rdy_e, ov_e, gt_e, eq_e, lt_e;
   logic rdy_f, ov_f, gt_f, eq_f, lt_f;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        sm;
      logic [2:0]  flags;   // {gt, eq, lt}
      int          lat_e;
   } vec_t;

   vec_t vecs[9];

   always #5 clk = ~clk;

   comparator_seq #(.WIDTH(16), .CHUNK(2), .EARLY_EXIT(1)) dut_e (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_e),
      .a(a), .b(b), .signed_mode(signed_mode),
      .out_valid(ov_e), .out_ready(out_ready),
      .a_gt_b(gt_e), .a_eq_b(eq_e), .a_lt_b(lt_e)
   );

   comparator_seq #(.WIDTH(16), .CHUNK(2), .EARLY_EXIT(0)) dut_f (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_f),
      .a(a), .b(b), .signed_mode(signed_mode),
      .out_valid(ov_f), .out_ready(out_ready),
      .a_gt_b(gt_f), .a_eq_b(eq_f), .a_lt_b(lt_f)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while (!(rdy_e && rdy_f) && n < 30) begin
         @(negedge clk);
         n++;
      end
      check("idle_wait", {31'd0, rdy_e & rdy_f}, 32'd1);
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      logic       seen_e, seen_f;
      int         lat_e, lat_f;
      logic [2:0] fl_e, fl_f;
      wait_idle();
      a           = v.a;
      b           = v.b;
      signed_mode = v.sm;
      in_valid    = 1'b1;
      out_ready   = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      seen_e = 1'b0; seen_f = 1'b0;
      lat_e = 0; lat_f = 0;
      fl_e = '0; fl_f = '0;
      for (int k = 1; k <= 20 && !(seen_e && seen_f); k++) begin
         @(posedge clk);
         #1;
         if (!seen_e && ov_e) begin
            seen_e = 1'b1; lat_e = k; fl_e = {gt_e, eq_e, lt_e};
         end
         if (!seen_f && ov_f) begin
            seen_f = 1'b1; lat_f = k; fl_f = {gt_f, eq_f, lt_f};
         end
      end
      check({tag, "_lat_early"}, lat_e, v.lat_e);
      check({tag, "_lat_full"},  lat_f, 8);
      check({tag, "_flags_early"}, {29'd0, fl_e}, {29'd0, v.flags});
      check({tag, "_flags_full"},  {29'd0, fl_f}, {29'd0, v.flags});
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      vecs[0] = '{16'h8000, 16'h7FFF, 1'b0, 3'b100, 1};
      vecs[1] = '{16'h1234, 16'h1234, 1'b0, 3'b010, 8};
      vecs[2] = '{16'hFFFF, 16'h0001, 1'b1, 3'b001, 1};
      vecs[3] = '{16'hFFFF, 16'h0001, 1'b0, 3'b100, 1};
      vecs[4] = '{16'h0001, 16'h0002, 1'b0, 3'b001, 8};
      vecs[5] = '{16'h4001, 16'h0002, 1'b0, 3'b100, 1};
      vecs[6] = '{16'h8000, 16'h7FFF, 1'b1, 3'b001, 1};
      vecs[7] = '{16'h0100, 16'h0200, 1'b0, 3'b001, 4};
      vecs[8] = '{16'hFFFE, 16'hFFFF, 1'b1, 3'b001, 8};

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; signed_mode = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_in_ready", {30'd0, rdy_e, rdy_f}, 32'h3);
      check("reset_out_valid", {30'd0, ov_e, ov_f}, 32'h0);
      check("reset_flags", {26'd0, gt_e, eq_e, lt_e, gt_f, eq_f, lt_f}, 32'h0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 9; i++) begin
         run_vec(vecs[i], $sformatf("vec%0d", i));
      end

      // Backpressure: result held while out_ready is low, new requests ignored
      wait_idle();
      a = 16'h8000; b = 16'h7FFF; signed_mode = 1'b0;
      in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk);
      #1 in_valid = 1'b0;
      n = 0;
      while (!(ov_e && ov_f) && n < 20) begin
         @(posedge clk);
         #1 n++;
      end
      check("bp_valid_reached", {30'd0, ov_e, ov_f}, 32'h3);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         in_valid    = 1'b1;
         a           = 16'h1111 * i[15:0];
         b           = 16'hFFFF;
         signed_mode = 1'b1;
         @(posedge clk);
         #1;
         check("bp_out_valid", {30'd0, ov_e, ov_f}, 32'h3);
         check("bp_flags", {26'd0, gt_e, eq_e, lt_e, gt_f, eq_f, lt_f}, 32'h24);
         check("bp_in_ready", {30'd0, rdy_e, rdy_f}, 32'h0);
      end
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp_after_out_valid", {30'd0, ov_e, ov_f}, 32'h0);
      check("bp_after_in_ready", {30'd0, rdy_e, rdy_f}, 32'h3);
      check("bp_flags_kept", {26'd0, gt_e, eq_e, lt_e, gt_f, eq_f, lt_f}, 32'h24);

      // Reset in the middle of a scan aborts the transaction
      wait_idle();
      a = 16'h0001; b = 16'h0002; signed_mode = 1'b0;
      in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("midscan_busy", {30'd0, rdy_e, rdy_f}, 32'h0);
      rst = 1'b1;
      #1;
      check("midscan_rst_out_valid", {30'd0, ov_e, ov_f}, 32'h0);
      check("midscan_rst_flags", {26'd0, gt_e, eq_e, lt_e, gt_f, eq_f, lt_f}, 32'h0);
      check("midscan_rst_in_ready", {30'd0, rdy_e, rdy_f}, 32'h3);
      @(negedge clk);
      rst = 1'b0;
      run_vec('{16'h0003, 16'h0003, 1'b0, 3'b010, 8}, "post_reset");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
